// File: rtl/dma_dsc_pkg.sv
// Shared definitions for the DMA descriptor cache: default geometry,
// address-width helper, popcount helper and the read-result record.
package dma_dsc_pkg;

    localparam int DSC_DATA_WIDTH  = 13;
    localparam int DSC_NUM_ENTRIES = 4;
    localparam int DSC_MAX_DW      = 64;

    typedef struct packed {
        logic                  hit;
        logic [DSC_MAX_DW-1:0] data;
    } rd_result_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int dsc_aw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int k = 0; k < 64; k++) begin
            c = c + {6'd0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/dma_dsc_cache_ram.sv
// Descriptor data store: one write port, registered read address, no reset
// so the array can live in a vendor RAM primitive.
module dma_dsc_cache_ram #(
    parameter int DW = 13,
    parameter int NE = 4,
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [AW-1:0] raddr_q_o,
    output logic [DW-1:0] rdata_o
);

    localparam logic [AW:0] NE_L = (AW+1)'(NE);

    logic [DW-1:0] mem_q [NE];
    logic [AW-1:0] raddr_q;

    // Write port; indices beyond the array are dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && ({1'b0, waddr_i} < NE_L)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read address register, advanced only for accepted requests.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            raddr_q <= raddr_i;
        end
    end

    assign raddr_q_o = raddr_q;
    assign rdata_o   = ({1'b0, raddr_q} < NE_L) ? mem_q[raddr_q] : '0;

endmodule

// File: rtl/dma_dsc_cache.sv
// DMA descriptor cache: data RAM plus valid bits, invalidation, occupancy
// tracking, write-to-read forwarding and a holdable read pipeline.
module dma_dsc_cache
    import dma_dsc_pkg::*;
#(
    parameter int DATA_WIDTH  = DSC_DATA_WIDTH,
    parameter int NUM_ENTRIES = DSC_NUM_ENTRIES,
    parameter int OUT_REG     = 1,
    localparam int AW         = dsc_aw(NUM_ENTRIES)
) (
    input  logic                   CLK,
    input  logic                   ARST_N,
    input  logic                   WR_EN,
    input  logic [AW-1:0]          WR_ADDR,
    input  logic [DATA_WIDTH-1:0]  WR_DATA,
    input  logic                   RD_REQ,
    input  logic [AW-1:0]          RD_ADDR,
    input  logic                   RD_HOLD,
    input  logic                   INV_EN,
    input  logic [AW-1:0]          INV_ADDR,
    input  logic                   INV_ALL,
    output logic                   RD_VALID,
    output logic                   RD_HIT,
    output logic [DATA_WIDTH-1:0]  RD_DATA,
    output logic [NUM_ENTRIES-1:0] VALID_VEC,
    output logic [AW:0]            OCCUPANCY,
    output logic                   FULL,
    output logic                   EMPTY
);

    localparam logic [AW:0]            N_L   = (AW+1)'(NUM_ENTRIES);
    localparam logic [NUM_ENTRIES-1:0] ONE_L = NUM_ENTRIES'(1'b1);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] wr_mask_s, inv_mask_s;
    logic [AW:0]            occ_q;
    logic                   full_q, empty_q;
    logic                   s1_vld_q;
    logic [AW-1:0]          s1_addr_s;
    logic [DATA_WIDTH-1:0]  ram_rdata_s;
    logic                   wr_ok_s, inv_ok_s, rd_acc_s, s1_in_rng_s;
    logic [6:0]             pop_s;

    assign wr_ok_s     = WR_EN  & ({1'b0, WR_ADDR}   < N_L);
    assign inv_ok_s    = INV_EN & ({1'b0, INV_ADDR}  < N_L);
    assign rd_acc_s    = RD_REQ & ~RD_HOLD;
    assign s1_in_rng_s = ({1'b0, s1_addr_s} < N_L);

    dma_dsc_cache_ram #(
        .DW (DATA_WIDTH),
        .NE (NUM_ENTRIES),
        .AW (AW)
    ) u_ram (
        .clk_i     (CLK),
        .we_i      (wr_ok_s),
        .waddr_i   (WR_ADDR),
        .wdata_i   (WR_DATA),
        .re_i      (rd_acc_s),
        .raddr_i   (RD_ADDR),
        .raddr_q_o (s1_addr_s),
        .rdata_o   (ram_rdata_s)
    );

    // Valid update order: global invalidate beats a write, a write beats a
    // single-entry invalidate of the same index.
    assign wr_mask_s  = wr_ok_s  ? (ONE_L << WR_ADDR)  : '0;
    assign inv_mask_s = inv_ok_s ? (ONE_L << INV_ADDR) : '0;
    assign valid_d    = INV_ALL ? '0 : ((valid_q & ~inv_mask_s) | wr_mask_s);
    assign pop_s      = popcount64(64'(valid_d));

    // Valid bits, occupancy flags and the stage-1 request valid.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            valid_q  <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            s1_vld_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            occ_q    <= (AW+1)'(pop_s);
            full_q   <= (pop_s == 7'(NUM_ENTRIES));
            empty_q  <= (pop_s == 7'd0);
            s1_vld_q <= RD_HOLD ? s1_vld_q : RD_REQ;
        end
    end

    assign VALID_VEC = valid_q;
    assign OCCUPANCY = occ_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;

    if (OUT_REG != 0) begin : g_oreg
        rd_result_t res_s, res_d, res_q;
        logic       vld_d, vld_q;
        logic       fwd_s;

        // Result as seen after this edge's valid update, with write-first data.
        always_comb begin
            res_s = '0;
            fwd_s = wr_ok_s && (WR_ADDR == s1_addr_s);
            if (s1_vld_q && s1_in_rng_s && valid_d[s1_addr_s]) begin
                res_s.hit = 1'b1;
                if (fwd_s) begin
                    res_s.data = DSC_MAX_DW'(WR_DATA);
                end else begin
                    res_s.data = DSC_MAX_DW'(ram_rdata_s);
                end
            end else begin
                res_s.hit = 1'b0;
            end
            if (RD_HOLD) begin
                res_d = res_q;
                vld_d = vld_q;
            end else begin
                res_d = res_s;
                vld_d = s1_vld_q;
            end
        end

        // Output register.
        always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N) begin
                res_q <= '0;
                vld_q <= 1'b0;
            end else begin
                res_q <= res_d;
                vld_q <= vld_d;
            end
        end

        assign RD_VALID = vld_q;
        assign RD_HIT   = res_q.hit;
        assign RD_DATA  = res_q.data[DATA_WIDTH-1:0];
    end else begin : g_comb
        logic hit_s;

        assign hit_s    = s1_vld_q & s1_in_rng_s & valid_q[s1_addr_s];
        assign RD_VALID = s1_vld_q;
        assign RD_HIT   = hit_s;
        assign RD_DATA  = hit_s ? ram_rdata_s : '0;
    end

endmodule

// File: tb/tb_dma_dsc_cache.sv
// Scoreboard bench for dma_dsc_cache: a 4x13 OUT_REG=1 instance and a
// 5x32 OUT_REG=0 instance driven side by side against an abstract model.
module tb_dma_dsc_cache;

    typedef struct {
        int          cyc;
        bit          hit;
        logic [31:0] data;
    } exp_t;

    logic        CLK    = 1'b0;
    logic        ARST_N = 1'b0;

    logic        wr_en    [2];
    logic [2:0]  wr_addr  [2];
    logic [31:0] wr_data  [2];
    logic        rd_req   [2];
    logic [2:0]  rd_addr  [2];
    logic        rd_hold  [2];
    logic        inv_en   [2];
    logic [2:0]  inv_addr [2];
    logic        inv_all  [2];

    logic        a_valid, a_hit, a_full, a_empty;
    logic [12:0] a_data;
    logic [3:0]  a_vv;
    logic [2:0]  a_occ;
    logic        b_valid, b_hit, b_full, b_empty;
    logic [31:0] b_data;
    logic [4:0]  b_vv;
    logic [3:0]  b_occ;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        mon_h0;

    bit   [7:0]  mval [2];
    logic [31:0] mmem [2][8];
    int          pend_addr [2][4];
    int          pend_rem  [2][4];
    int          pend_n    [2];
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    exp_t        last   [2];
    bit          last_v [2];

    dma_dsc_cache u_dut_a (
        .CLK       (CLK),
        .ARST_N    (ARST_N),
        .WR_EN     (wr_en[0]),
        .WR_ADDR   (wr_addr[0][1:0]),
        .WR_DATA   (wr_data[0][12:0]),
        .RD_REQ    (rd_req[0]),
        .RD_ADDR   (rd_addr[0][1:0]),
        .RD_HOLD   (rd_hold[0]),
        .INV_EN    (inv_en[0]),
        .INV_ADDR  (inv_addr[0][1:0]),
        .INV_ALL   (inv_all[0]),
        .RD_VALID  (a_valid),
        .RD_HIT    (a_hit),
        .RD_DATA   (a_data),
        .VALID_VEC (a_vv),
        .OCCUPANCY (a_occ),
        .FULL      (a_full),
        .EMPTY     (a_empty)
    );

    dma_dsc_cache #(
        .DATA_WIDTH  (32),
        .NUM_ENTRIES (5),
        .OUT_REG     (0)
    ) u_dut_b (
        .CLK       (CLK),
        .ARST_N    (ARST_N),
        .WR_EN     (wr_en[1]),
        .WR_ADDR   (wr_addr[1]),
        .WR_DATA   (wr_data[1]),
        .RD_REQ    (rd_req[1]),
        .RD_ADDR   (rd_addr[1]),
        .RD_HOLD   (rd_hold[1]),
        .INV_EN    (inv_en[1]),
        .INV_ADDR  (inv_addr[1]),
        .INV_ALL   (inv_all[1]),
        .RD_VALID  (b_valid),
        .RD_HIT    (b_hit),
        .RD_DATA   (b_data),
        .VALID_VEC (b_vv),
        .OCCUPANCY (b_occ),
        .FULL      (b_full),
        .EMPTY     (b_empty)
    );

    always #5 CLK = ~CLK;

    function automatic int ne(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] dmask(input int i);
        return (i == 0) ? 32'h0000_1FFF : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d: got 0x%0h, expected 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mval[i]   = 8'h00;
            pend_n[i] = 0;
            last_v[i] = 1'b0;
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    // One clock edge of the reference: state update, then any result whose
    // pipeline countdown expires is produced from the post-edge state.
    task automatic model_step(input int i);
        bit [7:0] v;
        exp_t     e;
        int       a;
        v = mval[i];
        if (inv_en[i] && int'(inv_addr[i]) < ne(i)) v[inv_addr[i]] = 1'b0;
        if (wr_en[i] && int'(wr_addr[i]) < ne(i)) begin
            v[wr_addr[i]] = 1'b1;
            mmem[i][wr_addr[i]] = wr_data[i] & dmask(i);
        end
        if (inv_all[i]) v = 8'h00;
        mval[i] = v;
        if (!rd_hold[i]) begin
            if (rd_req[i]) begin
                pend_addr[i][pend_n[i]] = int'(rd_addr[i]);
                pend_rem[i][pend_n[i]]  = lat(i);
                pend_n[i]++;
            end
            for (int k = 0; k < pend_n[i]; k++) pend_rem[i][k]--;
            while (pend_n[i] > 0 && pend_rem[i][0] == 0) begin
                a      = pend_addr[i][0];
                e.cyc  = cyc;
                e.hit  = (a < ne(i)) && v[a];
                e.data = e.hit ? mmem[i][a] : 32'h0;
                if (i == 0) exp_a.push_back(e);
                else        exp_b.push_back(e);
                for (int k = 0; k < pend_n[i] - 1; k++) begin
                    pend_addr[i][k] = pend_addr[i][k+1];
                    pend_rem[i][k]  = pend_rem[i][k+1];
                end
                pend_n[i]--;
            end
        end
    endtask

    task automatic mon(input int i, input logic h, input logic v, input logic hit,
                       input logic [31:0] d, input logic [7:0] vv, input logic [3:0] occ,
                       input logic full, input logic empty);
        exp_t e;
        bit   due;
        int   cnt;
        cnt = $countones(mval[i]);
        chk("valid_vec", i, 32'(vv), 32'(mval[i]));
        chk("occupancy", i, 32'(occ), cnt);
        chk("full", i, 32'(full), 32'(cnt == ne(i)));
        chk("empty", i, 32'(empty), 32'(cnt == 0));
        due = 1'b0;
        if (i == 0) begin
            if (exp_a.size() > 0 && exp_a[0].cyc == cyc) begin
                due = 1'b1;
                e   = exp_a.pop_front();
            end
        end else begin
            if (exp_b.size() > 0 && exp_b[0].cyc == cyc) begin
                due = 1'b1;
                e   = exp_b.pop_front();
            end
        end
        if (h) begin
            chk("hold_valid", i, 32'(v), 32'(last_v[i]));
            if (last_v[i]) begin
                chk("hold_hit", i, 32'(hit), 32'(last[i].hit));
                chk("hold_data", i, d, last[i].data);
            end
        end else if (due) begin
            chk("rd_valid", i, 32'(v), 32'd1);
            chk("rd_hit", i, 32'(hit), 32'(e.hit));
            chk("rd_data", i, d, e.data);
            last[i]   = e;
            last_v[i] = 1'b1;
        end else begin
            chk("rd_valid_idle", i, 32'(v), 32'd0);
            last_v[i] = 1'b0;
        end
    endtask

    // Reference model advances on every active edge outside reset.
    initial forever begin
        @(posedge CLK);
        cyc++;
        if (ARST_N) begin
            model_step(0);
            model_step(1);
        end
    end

    // Monitor: compares DUT outputs shortly after each edge.
    initial forever begin
        @(posedge CLK);
        mon_h0 = rd_hold[0];
        #1;
        mon(0, mon_h0, a_valid, a_hit, 32'(a_data), 8'(a_vv), 4'(a_occ), a_full, a_empty);
        mon(1, 1'b0, b_valid, b_hit, b_data, 8'(b_vv), b_occ, b_full, b_empty);
    end

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            wr_en[i]    = 1'b0;
            wr_addr[i]  = 3'd0;
            wr_data[i]  = 32'd0;
            rd_req[i]   = 1'b0;
            rd_addr[i]  = 3'd0;
            rd_hold[i]  = 1'b0;
            inv_en[i]   = 1'b0;
            inv_addr[i] = 3'd0;
            inv_all[i]  = 1'b0;
        end
    endtask

    task automatic wr(input int i, input int a, input logic [31:0] d);
        wr_en[i]   = 1'b1;
        wr_addr[i] = 3'(a);
        wr_data[i] = d & dmask(i);
    endtask

    task automatic rd(input int i, input int a);
        rd_req[i]  = 1'b1;
        rd_addr[i] = 3'(a);
    endtask

    task automatic tick();
        @(negedge CLK);
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (3) @(negedge CLK);
        ARST_N = 1'b1;
        tick();

        // Basic write/read hit, then a miss on an unwritten entry.
        wr(0, 2, 32'h1A5);                 tick();
        rd(0, 2);                          tick();
        repeat (3) tick();
        rd(0, 3);                          tick();
        for (int k = 0; k < 4; k++) begin
            wr(0, k, $urandom);            tick();
        end
        repeat (2) tick();

        // Write lands in the cycle the read samples the array.
        rd(0, 1);                          tick();
        wr(0, 1, 32'h0F0);                 tick();
        repeat (3) tick();

        // Write beats single invalidate; global invalidate beats write.
        wr(0, 0, 32'h055); inv_en[0] = 1'b1; inv_addr[0] = 3'd0; tick();
        wr(0, 3, 32'h0AA); inv_all[0] = 1'b1;                    tick();
        repeat (2) tick();

        // Four back-to-back reads with a three-cycle hold in the middle.
        for (int k = 0; k < 4; k++) begin
            wr(0, k, 32'h100 + 32'(k));    tick();
        end
        rd(0, 0);                          tick();
        rd(0, 1);                          tick();
        rd(0, 2);
        rd_hold[0] = 1'b1;
        repeat (3) @(negedge CLK);
        rd_hold[0] = 1'b0;                 tick();
        rd(0, 3);                          tick();
        repeat (4) tick();

        // Five-entry, 1-cycle-latency instance: in- and out-of-range accesses.
        wr(1, 4, 32'hDEAD_BEEF);           tick();
        rd(1, 4);                          tick();
        rd(1, 7);                          tick();
        wr(1, 6, 32'h1234_5678); rd(1, 6); tick();
        inv_en[1] = 1'b1; inv_addr[1] = 3'd7; rd(1, 4); tick();
        wr(1, 0, 32'hCAFE_0001); rd(1, 0); tick();
        repeat (2) tick();

        // Randomized traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                wr_en[i]    = ($urandom_range(0, 99) < 40);
                wr_addr[i]  = 3'($urandom_range(0, (i == 0) ? 3 : 7));
                wr_data[i]  = $urandom & dmask(i);
                rd_req[i]   = ($urandom_range(0, 99) < 60);
                rd_addr[i]  = 3'($urandom_range(0, (i == 0) ? 3 : 7));
                inv_en[i]   = ($urandom_range(0, 99) < 15);
                inv_addr[i] = 3'($urandom_range(0, (i == 0) ? 3 : 7));
                inv_all[i]  = ($urandom_range(0, 99) < 3);
                rd_hold[i]  = (i == 0) && ($urandom_range(0, 99) < 20);
            end
            @(negedge CLK);
        end
        idle();
        repeat (4) tick();

        // Reset while results are visible and in flight.
        for (int k = 0; k < 4; k++) begin
            wr(0, k, 32'h0200 + 32'(k)); wr(1, k, 32'h0300 + 32'(k)); tick();
        end
        rd(0, 1); rd(1, 2);                tick();
        rd(0, 2); rd(1, 3);                @(negedge CLK);
        idle();
        ARST_N = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 0, 32'(a_valid), 32'd0);
        chk("rst_hit", 0, 32'(a_hit), 32'd0);
        chk("rst_data", 0, 32'(a_data), 32'd0);
        chk("rst_vv", 0, 32'(a_vv), 32'd0);
        chk("rst_occ", 0, 32'(a_occ), 32'd0);
        chk("rst_full", 0, 32'(a_full), 32'd0);
        chk("rst_empty", 0, 32'(a_empty), 32'd1);
        chk("rst_valid", 1, 32'(b_valid), 32'd0);
        chk("rst_hit", 1, 32'(b_hit), 32'd0);
        chk("rst_data", 1, b_data, 32'd0);
        chk("rst_vv", 1, 32'(b_vv), 32'd0);
        chk("rst_occ", 1, 32'(b_occ), 32'd0);
        chk("rst_empty", 1, 32'(b_empty), 32'd1);
        repeat (2) @(negedge CLK);
        ARST_N = 1'b1;
        repeat (6) tick();

        chk("drain", 0, exp_a.size(), 32'd0);
        chk("drain", 1, exp_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_dsc_cache.md
Name: dma_dsc_cache

Overview:
- Parametrised successor to the fixed 4x13 DMA descriptor cache SRAM.
- Holds NUM_ENTRIES descriptor words of DATA_WIDTH bits, one or more per DMA channel, with a per-entry valid bit.
- Adds single-entry and global invalidate, hit/miss reporting, occupancy tracking, write-to-read forwarding and an output hold.
- Sits between the descriptor fetch engine (writer) and the channel arbiter/launcher (reader).

Parameters:
- DATA_WIDTH, 13, descriptor word width in bits (1..64).
- NUM_ENTRIES, 4, number of cache entries (2..64, any value).
- OUT_REG, 1, 1 = registered read data (2-cycle latency); 0 = 1-cycle latency.
- AW, derived as max(1, clog2(NUM_ENTRIES)), address width; not overridable.

Ports:
- CLK  in  1  single clock for all logic.
- ARST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  write strobe.
- WR_ADDR  in  AW  write entry index.
- WR_DATA  in  DATA_WIDTH  descriptor word to store.
- RD_REQ  in  1  read request.
- RD_ADDR  in  AW  read entry index.
- RD_HOLD  in  1  freezes the read pipeline and outputs.
- INV_EN  in  1  invalidate one entry.
- INV_ADDR  in  AW  entry index to invalidate.
- INV_ALL  in  1  invalidate all entries.
- RD_VALID  out  1  read result strobe.
- RD_HIT  out  1  addressed entry was valid.
- RD_DATA  out  DATA_WIDTH  read word; 0 on a miss.
- VALID_VEC  out  NUM_ENTRIES  per-entry valid bits.
- OCCUPANCY  out  AW+1  count of valid entries.
- FULL  out  1  OCCUPANCY == NUM_ENTRIES.
- EMPTY  out  1  OCCUPANCY == 0.

Behaviour:
- Reset (ARST_N low, async assert, sync release): VALID_VEC=0, OCCUPANCY=0, EMPTY=1, FULL=0, RD_VALID=0, RD_HIT=0, RD_DATA=0. Pipeline stage valids cleared. Data array is not reset; its contents are undefined.
- Reset mid-read drops the in-flight request; no RD_VALID is produced for it after release.
- Write: when WR_EN=1 and WR_ADDR<NUM_ENTRIES, the array stores WR_DATA and valid[WR_ADDR]=1 at the clock edge. Out-of-range writes are ignored.
- Valid-bit priority per edge: INV_ALL > WR_EN (same index) > INV_EN.
  - Write and INV_EN to the same index: the entry stays valid.
  - INV_ALL with WR_EN: data is written, but all valid bits are cleared.
- INV_EN with out-of-range INV_ADDR: no effect.
- OCCUPANCY equals popcount(VALID_VEC) in the same cycle as VALID_VEC. It may be implemented as an up/down counter but must never diverge from popcount. FULL and EMPTY are derived from OCCUPANCY.
- Read pipeline:
  - Stage 1 (address register) captures RD_ADDR when RD_REQ=1 and RD_HOLD=0. A request made while RD_HOLD=1 is not accepted; the requester keeps RD_REQ asserted until RD_HOLD falls.
  - Stage 2 (output register, present when OUT_REG=1) loads RD_DATA, RD_HIT and RD_VALID from stage 1 when RD_HOLD=0.
  - Latency from accepted RD_REQ to RD_VALID: 2 cycles (OUT_REG=1) or 1 cycle (OUT_REG=0).
  - Back-to-back requests give one result per cycle. RD_VALID is high for exactly one cycle per accepted request, except while held.
- RD_HOLD=1: stage 1 and the outputs keep their values, and RD_VALID stays asserted if it was asserted. Holding RD_HOLD for N cycles delays the result by exactly N cycles and never drops or duplicates it.
- RD_HIT reflects the valid bit after the update at the edge where the result is produced, so a same-cycle write gives hit=1 and a same-cycle invalidate gives hit=0.
- Forwarding: if WR_EN targets the address being read in the cycle the array is sampled, RD_DATA returns WR_DATA (write-first).
- Miss (invalid entry, or out-of-range RD_ADDR): RD_HIT=0, RD_DATA=0, RD_VALID=1.
- With OUT_REG=0, outputs are driven from stage 1 and the array read, not from an output register.

Decomposition:
- Shared package dma_dsc_pkg: DATA_WIDTH default, NUM_ENTRIES default, the AW function (clog2 with a minimum of 1), and a rd_result record type {hit, data}.
- One sub-module, dma_dsc_cache_ram: simple dual-port RAM with one write port and a registered read address. It holds data only and has no reset, so the tool maps it to micro-RAM. Valid bits, occupancy and forwarding live in dma_dsc_cache.

Test Plan:
- Reset, then write 0x1A5 to entry 2, then read entry 2 (OUT_REG=1) -> RD_VALID two cycles after the request, RD_HIT=1, RD_DATA=0x1A5, OCCUPANCY=1, EMPTY=0.
- Read entry 3 that was never written -> RD_VALID=1, RD_HIT=0, RD_DATA=0. Write entries 0..3 -> FULL=1, OCCUPANCY=4.
- Write entry 1 = 0x0F0 in the same cycle the read of entry 1 samples the array -> RD_DATA=0x0F0, RD_HIT=1.
- Entries 0..3 valid; INV_EN for entry 0 plus WR_EN to entry 0 in the same cycle -> entry 0 stays valid. Next cycle INV_ALL with WR_EN to entry 3 -> VALID_VEC=0, EMPTY=1.
- Four back-to-back reads with RD_HOLD high for 3 cycles in the middle -> four RD_VALID results in order, delayed by 3 cycles, outputs stable during the hold.
- Assert ARST_N low while a read is in flight -> all outputs 0 immediately; no RD_VALID after release. Repeat with NUM_ENTRIES=5, DATA_WIDTH=32 and OUT_REG=0: 1-cycle latency, and an RD_ADDR of 7 returns a miss.
